sdp_ram_pipelined: RTL and testbench

Parametrised simple dual-port RAM. Port A is write-only, with per-byte write enables. Port B is read-only, with an explicit read enable, a configurable read pipeline depth and a one-cycle valid strobe per accepted read. It replaces the fixed-latency simple dual-port RAM as the buffer primitive for datapath blocks that need deterministic read latency and defined read-during-write behaviour.

---
 rtl/sdp_ram_pipelined_pkg.sv | 20 ++
 rtl/sdp_ram_pipelined_if.sv | 35 +++
 rtl/sdp_ram_pipelined_rd_pipe.sv | 44 ++++
 rtl/sdp_ram_pipelined.sv | 99 +++++++++
 tb/tb_sdp_ram_pipelined.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdp_ram_pipelined_pkg.sv
// sdp_ram_pkg: shared types, limits and helpers for the
// pipelined simple dual-port RAM.
package sdp_ram_pkg;

   typedef enum logic {
      RDW_READ_FIRST  = 1'b0,
      RDW_WRITE_FIRST = 1'b1
   } rdw_mode_e;

   localparam int MAX_RD_LATENCY = 4;
   localparam int MIN_RD_LATENCY = 1;

   function automatic int num_lanes(
      input int data_width,
      input int byte_width
   );
      return data_width / byte_width;
   endfunction

endpackage

// File: rtl/sdp_ram_pipelined_if.sv
// sdp_ram_pipelined_if: write port A, read port B and
// status bundle of the pipelined simple dual-port RAM.
interface sdp_ram_pipelined_if
   import sdp_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);

   localparam int NL = num_lanes(DATA_WIDTH, BYTE_WIDTH);

   logic                  wena;
   logic [NL-1:0]         bea;
   logic [ADDR_WIDTH-1:0] addra;
   logic [DATA_WIDTH-1:0] dina;
   logic                  renb;
   logic [ADDR_WIDTH-1:0] addrb;
   logic [DATA_WIDTH-1:0] doutb;
   logic                  dvalb;
   logic                  oob_err;

   modport master (
      output wena, bea, addra, dina,
      output renb, addrb,
      input  doutb, dvalb, oob_err
   );

   modport slave (
      input  wena, bea, addra, dina,
      input  renb, addrb,
      output doutb, dvalb, oob_err
   );

endinterface

// File: rtl/sdp_ram_pipelined_rd_pipe.sv
// sdp_ram_rd_pipe: {valid, data} delay line behind the array
// read register; data only advances with its valid bit.
module sdp_ram_rd_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vld_in,
   input  logic [DATA_WIDTH-1:0] dat_in,
   output logic                  vld_out,
   output logic [DATA_WIDTH-1:0] dat_out
);

   if (STAGES == 0) begin : g_bypass
      assign vld_out = vld_in;
      assign dat_out = dat_in;
   end else begin : g_stages
      logic [STAGES-1:0]     vld_q;
      logic [DATA_WIDTH-1:0] dat_q [STAGES];

      // data clears with valid so doutb reads zero in reset
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++)
               dat_q[i] <= '0;
         end else begin
            vld_q[0] <= vld_in;
            if (vld_in)
               dat_q[0] <= dat_in;
            for (int i = 1; i < STAGES; i++) begin
               vld_q[i] <= vld_q[i-1];
               if (vld_q[i-1])
                  dat_q[i] <= dat_q[i-1];
            end
         end
      end

      assign vld_out = vld_q[STAGES-1];
      assign dat_out = dat_q[STAGES-1];
   end

endmodule

// File: rtl/sdp_ram_pipelined.sv
// sdp_ram_pipelined: byte-enabled write port, pipelined read
// port with valid strobe, collision bypass and range check.
module sdp_ram_pipelined
   import sdp_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_DEPTH  = 256,
   parameter int RD_LATENCY = 2,
   parameter int RDW_MODE   = 0
)(
   input logic                clk,
   input logic                rst,
   sdp_ram_pipelined_if.slave bus
);

   localparam int NL = num_lanes(DATA_WIDTH, BYTE_WIDTH);
   localparam int AW1 = ADDR_WIDTH + 1;
   localparam logic [AW1-1:0] DEPTH = AW1'(MEM_DEPTH);
   localparam bit WR_FIRST =
      RDW_MODE == int'(RDW_WRITE_FIRST);

   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_dw
      $fatal(1, "DATA_WIDTH not a multiple of BYTE_WIDTH");
   end
   if (RD_LATENCY < MIN_RD_LATENCY ||
       RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_lat
      $fatal(1, "RD_LATENCY out of range");
   end
   if (MEM_DEPTH < 1 ||
       MEM_DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
      $fatal(1, "MEM_DEPTH out of range");
   end

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic                  wr_ok;
   logic                  rd_ok;
   logic                  hit;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  rd_vld_q;
   logic [DATA_WIDTH-1:0] rd_dat_q;
   logic                  oob_q;

   assign wr_ok = {1'b0, bus.addra} < DEPTH;
   assign rd_ok = {1'b0, bus.addrb} < DEPTH;
   assign hit   = bus.wena && wr_ok &&
                  (bus.addra == bus.addrb);

   always_ff @(posedge clk) begin
      if (bus.wena && wr_ok)
         for (int i = 0; i < NL; i++)
            if (bus.bea[i])
               mem[bus.addra][i*BYTE_WIDTH +: BYTE_WIDTH]
                  <= bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
   end

   // the array read sees the pre-write word; write-first
   // overlays the enabled lanes of the same-edge write
   always_comb begin
      rd_word = mem[bus.addrb];
      if (WR_FIRST && hit)
         for (int i = 0; i < NL; i++)
            if (bus.bea[i])
               rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                  bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (!rd_ok)
         rd_word = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_vld_q <= 1'b0;
         rd_dat_q <= '0;
         oob_q    <= 1'b0;
      end else begin
         rd_vld_q <= bus.renb;
         oob_q    <= (bus.wena && !wr_ok) ||
                     (bus.renb && !rd_ok);
         if (bus.renb)
            rd_dat_q <= rd_word;
      end
   end

   sdp_ram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (RD_LATENCY - 1)
   ) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .vld_in  (rd_vld_q),
      .dat_in  (rd_dat_q),
      .vld_out (bus.dvalb),
      .dat_out (bus.doutb)
   );

   assign bus.oob_err = oob_q;

endmodule

// File: tb/tb_sdp_ram_pipelined.sv
// tb_sdp_ram_pipelined: four RAM instances (latency 1..4,
// alternating collision modes) against a word-level model.
module tb_sdp_ram_pipelined;

   localparam int DEPTH = 200;
   localparam int NI    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wena = 1'b0;
   logic [3:0]  bea = '0;
   logic [7:0]  addra = '0;
   logic [31:0] dina = '0;
   logic        renb = 1'b0;
   logic [7:0]  addrb = '0;

   logic [NI-1:0] dv;
   logic [NI-1:0] oe;
   logic [31:0]   dq [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      sdp_ram_pipelined_if #(
         .DATA_WIDTH (32),
         .BYTE_WIDTH (8),
         .ADDR_WIDTH (8)
      ) bus ();

      assign bus.wena  = wena;
      assign bus.bea   = bea;
      assign bus.addra = addra;
      assign bus.dina  = dina;
      assign bus.renb  = renb;
      assign bus.addrb = addrb;
      assign dv[g]     = bus.dvalb;
      assign dq[g]     = bus.doutb;
      assign oe[g]     = bus.oob_err;

      sdp_ram_pipelined #(
         .DATA_WIDTH (32),
         .BYTE_WIDTH (8),
         .ADDR_WIDTH (8),
         .MEM_DEPTH  (DEPTH),
         .RD_LATENCY (g + 1),
         .RDW_MODE   (g % 2)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   int n_cmp = 0;
   int n_bad = 0;
   int edge_n = 0;

   logic [31:0] ref_mem [256];
   bit          ev [NI][64];
   logic [31:0] ed [NI][64];
   bit          eo [64];
   logic [31:0] last_d [NI];

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] nw,
      input logic [3:0]  be
   );
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
      return r;
   endfunction

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s got=%h exp=%h t=%0t",
                tag, got, exp, $time);
      end
   endtask

   task automatic clear_sched();
      for (int s = 0; s < 64; s++) begin
         eo[s] = 1'b0;
         for (int k = 0; k < NI; k++) ev[k][s] = 1'b0;
      end
   endtask

   // model the coming edge, take it, then check all DUTs
   task automatic tick();
      logic [31:0] nw;
      logic [31:0] rv;
      int          s;
      bit          wbad;
      bit          rbad;
      wbad = int'(addra) >= DEPTH;
      rbad = int'(addrb) >= DEPTH;
      if (!rst) begin
         clear_sched();
      end else begin
         nw = merge(ref_mem[addra], dina, bea);
         for (int k = 0; k < NI; k++) begin
            if (renb) begin
               if (rbad)
                  rv = '0;
               else if (k % 2 == 1 && wena &&
                        addra == addrb)
                  rv = nw;
               else
                  rv = ref_mem[addrb];
               s = (edge_n + 1 + k) % 64;
               ev[k][s] = 1'b1;
               ed[k][s] = rv;
            end
         end
         if (wena && !wbad) ref_mem[addra] = nw;
         if ((wena && wbad) || (renb && rbad))
            eo[(edge_n + 1) % 64] = 1'b1;
      end
      @(posedge clk);
      edge_n++;
      #1;
      s = edge_n % 64;
      for (int k = 0; k < NI; k++) begin
         if (!rst) begin
            chk($sformatf("rst_dval%0d", k), 32'(dv[k]), 0);
            chk($sformatf("rst_dout%0d", k), dq[k], 0);
            chk($sformatf("rst_oob%0d", k), 32'(oe[k]), 0);
            last_d[k] = '0;
         end else begin
            if (ev[k][s]) last_d[k] = ed[k][s];
            chk($sformatf("dval%0d", k),
                32'(dv[k]), 32'(ev[k][s]));
            chk($sformatf("dout%0d", k), dq[k], last_d[k]);
            chk($sformatf("oob%0d", k),
                32'(oe[k]), 32'(eo[s]));
         end
         ev[k][s] = 1'b0;
      end
      eo[s] = 1'b0;
   endtask

   task automatic idle(input int n);
      wena = 1'b0;
      renb = 1'b0;
      bea  = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(
      input logic [7:0]  a,
      input logic [31:0] d,
      input logic [3:0]  b
   );
      wena = 1'b1; addra = a; dina = d; bea = b;
      renb = 1'b0;
      tick();
      wena = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a);
      renb = 1'b1; addrb = a;
      wena = 1'b0;
      tick();
      renb = 1'b0;
   endtask

   function automatic logic [7:0] rand_addr();
      if ($urandom_range(0, 7) == 0)
         return 8'($urandom_range(DEPTH, 255));
      return 8'($urandom_range(0, 15));
   endfunction

   initial begin
      clear_sched();
      for (int k = 0; k < NI; k++) last_d[k] = '0;

      // reset held, then idle after release
      rst = 1'b0;
      idle(3);
      rst = 1'b1;
      idle(5);

      // latency sweep across the four instances
      wr(8'd5, 32'hDEADBEEF, 4'hF);
      rd(8'd5);
      idle(5);

      // partial byte enables
      wr(8'd9, 32'h11223344, 4'hF);
      wr(8'd9, 32'hAABBCCDD, 4'b0101);
      rd(8'd9);
      idle(5);

      // streaming writes then back-to-back reads
      for (int i = 0; i < 16; i++)
         wr(8'(i), 32'(i * 3), 4'hF);
      for (int i = 0; i < 16; i++) begin
         renb = 1'b1; addrb = 8'(i);
         tick();
      end
      idle(6);

      // same-edge collision on addr 7
      wr(8'd7, 32'h0, 4'hF);
      idle(1);
      wena = 1'b1; addra = 8'd7;
      dina = 32'hCAFEF00D; bea = 4'b0011;
      renb = 1'b1; addrb = 8'd7;
      tick();
      idle(6);

      // out-of-range write and read on one edge
      wena = 1'b1; addra = 8'd250;
      dina = 32'h55AA55AA; bea = 4'hF;
      renb = 1'b1; addrb = 8'd250;
      tick();
      idle(5);
      rd(8'd7);
      idle(5);

      // randomized traffic incl. collisions and bad addrs
      for (int n = 0; n < 200; n++) begin
         wena  = 1'($urandom_range(0, 1));
         bea   = 4'($urandom);
         dina  = $urandom;
         addra = rand_addr();
         renb  = 1'($urandom_range(0, 1));
         addrb = ($urandom_range(0, 3) == 0) ?
                 addra : rand_addr();
         tick();
      end
      idle(6);

      // reset with reads still in flight
      for (int i = 1; i <= 3; i++) begin
         renb = 1'b1; addrb = 8'(i);
         tick();
      end
      renb = 1'b0;
      rst  = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
